dport_arbiter: RTL and testbench
================================

Name: dport_arbiter

Overview:
Shares the single memory data port (dread/dwrite address, data and byte-enable) between two requesters: master 0 (cpu data side) and master 1 (DMA/debug loader). Round-robin arbitration, one accepted access per cycle, pipelined reads with per-master return routing. Sits between cpu/DMA and memory inside the test system; instruction port untouched.

Parameters:
AW, 16, address width
DW, 16, data width; byte-enable width BW = DW/8
RD_LAT, 1, cycles from dread_addr applied to dread_data valid (0 = combinational memory read)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 access request
m0_we  in  BW  byte write enables; all-zero = read
m0_addr  in  AW  access address
m0_wdata  in  DW  write data
m0_gnt  out  1  request accepted at this edge when m0_req && m0_gnt
m0_rvalid  out  1  read data valid, one cycle per read
m0_rdata  out  DW  read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as master 0
dread_addr  out  AW  to memory
dread_data  in  DW  from memory
dwrite_addr  out  AW  to memory
dwrite_data  out  DW  to memory
dwrite_en  out  BW  to memory byte write enables

Behaviour:
- Reset: dwrite_en=0, dread_addr=0, dwrite_addr=0, dwrite_data=0, mX_rvalid=0, mX_rdata=0, rr pointer = master 1 last (master 0 wins first tie), read-tag pipeline cleared.
- Grant combinational from mX_req and registered state; no gnt without req; at most one gnt per cycle.
- Arbitration: one requester -> grant it. Both -> grant master not granted last; pointer updates only on acceptance (req && gnt at edge).
- Accept at end of cycle N: memory-side outputs registered, valid during cycle N+1 only.
  - Write (we != 0): dwrite_addr=addr, dwrite_data=wdata, dwrite_en=we for cycle N+1; dwrite_en returns to 0 in N+2 unless another write accepted. No rvalid.
  - Read (we == 0): dread_addr=addr in N+1 (held afterwards until next read); dwrite_en=0.
- Read return: tag (valid, master id) shifts through RD_LAT+1 stage pipe; dread_data sampled at end of cycle N+1+RD_LAT into winner's mX_rdata; mX_rvalid high for exactly cycle N+2+RD_LAT. Other master's rdata/rvalid unchanged.
- Back-to-back accepts every cycle permitted; up to RD_LAT+1 reads in flight; returns in acceptance order, never merged or dropped.
- mX_rdata holds last returned value until next return to that master.
- Reset mid-operation: in-flight reads discarded, no rvalid after reset deasserts until new read accepted; dwrite_en forced 0 asynchronously.
- Request must stay stable until accepted; masters may drop req without penalty (pointer unchanged).

Optional Feature:
Macro DPORT_ARBITER_LOCK_EN. Defined: extra input m0_lock (1 bit). Accepted master 0 access with m0_lock=1 sets lock; while set m1_gnt=0 regardless of m1_req; cleared by accepted master 0 access with m0_lock=0 or by reset. Enables atomic read-modify-write by cpu. Undefined: port absent, pure round-robin.

Test Plan:
- Reset, then m0 read addr 0x0010 (mem holds 0x1234), RD_LAT=1 -> accept cycle N, dread_addr=0x0010 in N+1, m0_rvalid=1, m0_rdata=0x1234 in N+3; m1_rvalid stays 0.
- m0 write addr 0x0020, we=2'b01, wdata 0xABCD -> dwrite_en=2'b01, dwrite_addr=0x0020, dwrite_data=0xABCD for exactly one cycle; no rvalid; readback returns low byte 0xCD.
- Both requesting reads continuously 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; six rvalids in same order with correct per-address data.
- Back-to-back m0 reads 0x0000..0x0003 every cycle, RD_LAT=2 -> four consecutive m0_rvalid cycles, data in address order.
- Reset asserted while two reads in flight -> dwrite_en=0 immediately, no rvalid after release, next read returns correct data.
- LOCK_EN build: m0 read lock=1, m1_req high, m0 write lock=0 -> m1_gnt 0 until cycle after m0 unlocking write accepted, then m1 granted.

Source files
------------

// File: rtl/dport_arbiter.sv
// dport_arbiter: round-robin sharing of the memory data port by two masters.
// Optional macro DPORT_ARBITER_LOCK_EN adds m0_lock so master 0 can hold the port.
module dport_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1,
    localparam int BW    = DW / 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic [BW-1:0] m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
`ifdef DPORT_ARBITER_LOCK_EN
    input  logic          m0_lock,
`endif
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic [BW-1:0] m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] dread_addr,
    input  logic [DW-1:0] dread_data,
    output logic [AW-1:0] dwrite_addr,
    output logic [DW-1:0] dwrite_data,
    output logic [BW-1:0] dwrite_en
);

    // last_m1 = 1 means master 1 won the most recent accepted access
    logic          last_m1;
    logic          m1_block;
    logic          take0;
    logic          take1;
    logic          accept;
    logic          acc_read;
    logic [BW-1:0] acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    // Read tags: bit k is valid during the (k+1)th cycle after acceptance
    logic [RD_LAT:0] tag_vld;
    logic [RD_LAT:0] tag_id;
    logic            ret0;
    logic            ret1;

`ifdef DPORT_ARBITER_LOCK_EN
    logic lock_q;

    // Lock follows m0_lock on every accepted master 0 access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else if (take0) begin
            lock_q <= m0_lock;
        end
    end

    assign m1_block = lock_q;
`else
    assign m1_block = 1'b0;
`endif

    // Grant: single requester wins, ties go to the master not served last
    always_comb begin
        m0_gnt = m0_req & (~m1_req | m1_block | last_m1);
        m1_gnt = m1_req & ~m1_block & (~m0_req | ~last_m1);
    end

    assign take0  = m0_req & m0_gnt;
    assign take1  = m1_req & m1_gnt;
    assign accept = take0 | take1;

    // Select the accepted master's access fields
    always_comb begin
        acc_we    = m0_we;
        acc_addr  = m0_addr;
        acc_wdata = m0_wdata;
        if (take1) begin
            acc_we    = m1_we;
            acc_addr  = m1_addr;
            acc_wdata = m1_wdata;
        end
        acc_read = accept & (acc_we == '0);
    end

    // Round-robin pointer moves only when an access is actually taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_m1 <= 1'b1;
        end else if (accept) begin
            last_m1 <= take1;
        end
    end

    // Memory-side outputs: write strobes last one cycle, read address holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dread_addr  <= '0;
            dwrite_addr <= '0;
            dwrite_data <= '0;
            dwrite_en   <= '0;
        end else begin
            dwrite_en <= '0;
            if (accept) begin
                if (acc_we != '0) begin
                    dwrite_addr <= acc_addr;
                    dwrite_data <= acc_wdata;
                    dwrite_en   <= acc_we;
                end else begin
                    dread_addr <= acc_addr;
                end
            end
        end
    end

    // Read-tag shift pipe, one stage per cycle of memory latency plus one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= acc_read;
            tag_id[0]  <= take1;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign ret0 = tag_vld[RD_LAT] & ~tag_id[RD_LAT];
    assign ret1 = tag_vld[RD_LAT] & tag_id[RD_LAT];

    // Route returning read data to its owner; the other master keeps its data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= ret0;
            m1_rvalid <= ret1;
            if (ret0) begin
                m0_rdata <= dread_data;
            end
            if (ret1) begin
                m1_rdata <= dread_data;
            end
        end
    end

endmodule

// File: tb/tb_dport_arbiter.sv
// tb_dport_arbiter: directed vectors against two arbiters (RD_LAT 1 and 2)
// sharing one stimulus set and one behavioural memory.
module tb_dport_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic reset;

    logic          m0_req;
    logic [BW-1:0] m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m1_req;
    logic [BW-1:0] m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
`ifdef DPORT_ARBITER_LOCK_EN
    logic          m0_lock;
`endif

    logic          a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [DW-1:0] a_m0_rdata, a_m1_rdata;
    logic [AW-1:0] a_raddr, a_waddr;
    logic [DW-1:0] a_rdata, a_wdata;
    logic [BW-1:0] a_wen;

    logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata;
    logic [AW-1:0] b_raddr, b_waddr;
    logic [DW-1:0] b_rdata, b_wdata;
    logic [BW-1:0] b_wen;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dport_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata),
`ifdef DPORT_ARBITER_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid),
        .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid),
        .m1_rdata(a_m1_rdata),
        .dread_addr(a_raddr), .dread_data(a_rdata),
        .dwrite_addr(a_waddr), .dwrite_data(a_wdata),
        .dwrite_en(a_wen)
    );

    dport_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata),
`ifdef DPORT_ARBITER_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid),
        .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid),
        .m1_rdata(b_m1_rdata),
        .dread_addr(b_raddr), .dread_data(b_rdata),
        .dwrite_addr(b_waddr), .dwrite_data(b_wdata),
        .dwrite_en(b_wen)
    );

    // Memory: word i holds {i, ~i}, except 0x10 holds 0x1234
    logic [15:0] mem [256];
    bit          mem_ready = 1'b0;
    logic [15:0] a_rd_q;
    logic [15:0] b_rd_q1;
    logic [15:0] b_rd_q2;

    function automatic logic [15:0] init_val(input logic [7:0] i);
        return (i == 8'h10) ? 16'h1234 : {i, ~i};
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
            mem_ready <= 1'b1;
        end else begin
            if (a_wen[0]) mem[a_waddr[7:0]][7:0]  <= a_wdata[7:0];
            if (a_wen[1]) mem[a_waddr[7:0]][15:8] <= a_wdata[15:8];
        end
    end

    always @(posedge clk) begin
        a_rd_q  <= mem[a_raddr[7:0]];
        b_rd_q1 <= mem[b_raddr[7:0]];
        b_rd_q2 <= b_rd_q1;
    end

    assign a_rdata = a_rd_q;
    assign b_rdata = b_rd_q2;

    typedef struct {
        logic        r0;
        logic [1:0]  w0;
        logic [15:0] a0;
        logic [15:0] d0;
        logic        r1;
        logic [15:0] a1;
        logic        g0;
        logic        g1;
        logic        rv0;
        logic        rv1;
        logic [15:0] rd;
        logic [1:0]  wen;
        logic [15:0] wa;
        logic [15:0] wd;
        logic [15:0] ra;
    } vec_t;

    vec_t tbl [21];
    logic [15:0] exp_rd0;
    logic [15:0] exp_rd1;
    logic [15:0] b_exp [4];

    function automatic vec_t v(
        input logic r0, input logic [1:0] w0,
        input logic [15:0] a0, input logic [15:0] d0,
        input logic r1, input logic [15:0] a1,
        input logic [3:0] ex, input logic [15:0] rd,
        input logic [1:0] wen, input logic [15:0] wa,
        input logic [15:0] wd, input logic [15:0] ra);
        vec_t t;
        t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
        t.r1 = r1; t.a1 = a1;
        t.g0 = ex[3]; t.g1 = ex[2]; t.rv0 = ex[1]; t.rv1 = ex[0];
        t.rd = rd; t.wen = wen; t.wa = wa; t.wd = wd; t.ra = ra;
        return t;
    endfunction

    function automatic vec_t iv(
        input logic [3:0] ex, input logic [15:0] rd,
        input logic [1:0] wen, input logic [15:0] ra);
        return v(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 16'h0,
                 ex, rd, wen, 16'h0020, 16'hABCD, ra);
    endfunction

    function automatic vec_t rv(
        input logic r0, input logic [15:0] a0,
        input logic r1, input logic [15:0] a1,
        input logic [3:0] ex, input logic [15:0] rd,
        input logic [15:0] ra);
        return v(r0, 2'd0, a0, 16'h0, r1, a1,
                 ex, rd, 2'd0, 16'h0, 16'h0, ra);
    endfunction

    task automatic chk1(input string nm, input logic act,
                        input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(
        input logic r0, input logic [1:0] w0,
        input logic [15:0] a0, input logic [15:0] d0,
        input logic r1, input logic [1:0] w1,
        input logic [15:0] a1, input logic [15:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 16'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
`ifdef DPORT_ARBITER_LOCK_EN
        m0_lock = 1'b0;
`endif
        exp_rd0 = 16'h0;
        exp_rd1 = 16'h0;
        b_exp[0] = 16'h00FF;
        b_exp[1] = 16'h01FE;
        b_exp[2] = 16'h02FD;
        b_exp[3] = 16'h03FC;

        tbl[0]  = rv(1'b1, 16'h0010, 1'b0, 16'h0, 4'b1000, 16'h0, 16'h0000);
        tbl[1]  = iv(4'b0000, 16'h0, 2'b00, 16'h0010);
        tbl[2]  = iv(4'b0000, 16'h0, 2'b00, 16'h0010);
        tbl[3]  = iv(4'b0010, 16'h1234, 2'b00, 16'h0010);
        tbl[4]  = v(1'b1, 2'b01, 16'h0020, 16'hABCD, 1'b0, 16'h0,
                    4'b1000, 16'h0, 2'b00, 16'h0, 16'h0, 16'h0010);
        tbl[5]  = iv(4'b0000, 16'h0, 2'b01, 16'h0010);
        tbl[6]  = iv(4'b0000, 16'h0, 2'b00, 16'h0010);
        tbl[7]  = rv(1'b1, 16'h0020, 1'b0, 16'h0, 4'b1000, 16'h0, 16'h0010);
        tbl[8]  = iv(4'b0000, 16'h0, 2'b00, 16'h0020);
        tbl[9]  = iv(4'b0000, 16'h0, 2'b00, 16'h0020);
        tbl[10] = iv(4'b0010, 16'h20CD, 2'b00, 16'h0020);
        tbl[11] = rv(1'b0, 16'h0, 1'b1, 16'h0005, 4'b0100, 16'h0, 16'h0020);
        tbl[12] = rv(1'b1, 16'h0000, 1'b1, 16'h0008, 4'b1000, 16'h0, 16'h0005);
        tbl[13] = rv(1'b1, 16'h0001, 1'b1, 16'h0008, 4'b0100, 16'h0, 16'h0000);
        tbl[14] = rv(1'b1, 16'h0001, 1'b1, 16'h0009, 4'b1001, 16'h05FA, 16'h0008);
        tbl[15] = rv(1'b1, 16'h0002, 1'b1, 16'h0009, 4'b0110, 16'h00FF, 16'h0001);
        tbl[16] = rv(1'b1, 16'h0002, 1'b1, 16'h000A, 4'b1001, 16'h08F7, 16'h0009);
        tbl[17] = rv(1'b1, 16'h0003, 1'b1, 16'h000A, 4'b0110, 16'h01FE, 16'h0002);
        tbl[18] = iv(4'b0001, 16'h09F6, 2'b00, 16'h000A);
        tbl[19] = iv(4'b0010, 16'h02FD, 2'b00, 16'h000A);
        tbl[20] = iv(4'b0001, 16'h0AF5, 2'b00, 16'h000A);

        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk16("rst.wen", 16'(a_wen), 16'h0);
        chk16("rst.raddr", a_raddr, 16'h0);
        chk16("rst.waddr", a_waddr, 16'h0);
        chk16("rst.wdata", a_wdata, 16'h0);
        chk1("rst.rv0", a_m0_rvalid, 1'b0);
        chk1("rst.rv1", a_m1_rvalid, 1'b0);
        chk16("rst.rd0", a_m0_rdata, 16'h0);
        chk16("rst.rd1", a_m1_rdata, 16'h0);
        chk1("rst.g0", a_m0_gnt, 1'b0);
        chk16("rst.b_wen", 16'(b_wen), 16'h0);
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, 2'd0, tbl[i].a1, 16'h0);
            @(negedge clk);
            if (tbl[i].rv0) exp_rd0 = tbl[i].rd;
            if (tbl[i].rv1) exp_rd1 = tbl[i].rd;
            chk1($sformatf("t%0d.g0", i), a_m0_gnt, tbl[i].g0);
            chk1($sformatf("t%0d.g1", i), a_m1_gnt, tbl[i].g1);
            chk1($sformatf("t%0d.rv0", i), a_m0_rvalid, tbl[i].rv0);
            chk1($sformatf("t%0d.rv1", i), a_m1_rvalid, tbl[i].rv1);
            chk16($sformatf("t%0d.rd0", i), a_m0_rdata, exp_rd0);
            chk16($sformatf("t%0d.rd1", i), a_m1_rdata, exp_rd1);
            chk16($sformatf("t%0d.wen", i), 16'(a_wen), 16'(tbl[i].wen));
            chk16($sformatf("t%0d.raddr", i), a_raddr, tbl[i].ra);
            if (tbl[i].wen != 2'b00) begin
                chk16($sformatf("t%0d.waddr", i), a_waddr, tbl[i].wa);
                chk16($sformatf("t%0d.wdata", i), a_wdata, tbl[i].wd);
            end
            next_cycle();
        end

        idle();
        repeat (3) next_cycle();

        // RD_LAT=2 instance: four back-to-back master 0 reads
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                drive(1'b1, 2'd0, 16'(k), 16'h0,
                      1'b0, 2'd0, 16'h0, 16'h0);
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 4) chk1($sformatf("b2b%0d.g0", k), b_m0_gnt, 1'b1);
            chk1($sformatf("b2b%0d.rv0", k), b_m0_rvalid,
                 (k >= 4) && (k <= 7));
            chk1($sformatf("b2b%0d.rv1", k), b_m1_rvalid, 1'b0);
            if ((k >= 4) && (k <= 7)) begin
                chk16($sformatf("b2b%0d.rd0", k), b_m0_rdata, b_exp[k-4]);
            end
            next_cycle();
        end

        // Reset with reads in flight and a write strobe on the bus
        drive(1'b1, 2'd0, 16'h0003, 16'h0, 1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk1("rf.g0a", a_m0_gnt, 1'b1);
        next_cycle();
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd0, 16'h0004, 16'h0);
        @(negedge clk);
        chk1("rf.g1", a_m1_gnt, 1'b1);
        next_cycle();
        drive(1'b1, 2'b11, 16'h0030, 16'hBEEF, 1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk1("rf.g0b", a_m0_gnt, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        chk16("rf.wen_pre", 16'(a_wen), 16'h0003);
        chk1("rf.rv0_pre", a_m0_rvalid, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk16("rf.wen_a", 16'(a_wen), 16'h0);
        chk16("rf.wen_b", 16'(b_wen), 16'h0);
        chk1("rf.rv0_a", a_m0_rvalid, 1'b0);
        chk16("rf.rd0_a", a_m0_rdata, 16'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1($sformatf("rf%0d.a_rv0", k), a_m0_rvalid, 1'b0);
            chk1($sformatf("rf%0d.a_rv1", k), a_m1_rvalid, 1'b0);
            chk1($sformatf("rf%0d.b_rv0", k), b_m0_rvalid, 1'b0);
            chk1($sformatf("rf%0d.b_rv1", k), b_m1_rvalid, 1'b0);
            chk16($sformatf("rf%0d.wen", k), 16'(a_wen), 16'h0);
            next_cycle();
        end

        // After reset master 0 wins the first tie; aborted write left no trace
        drive(1'b1, 2'd0, 16'h0030, 16'h0, 1'b1, 2'd0, 16'h0006, 16'h0);
        @(negedge clk);
        chk1("pr.g0", a_m0_gnt, 1'b1);
        chk1("pr.g1", a_m1_gnt, 1'b0);
        next_cycle();
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd0, 16'h0006, 16'h0);
        @(negedge clk);
        chk1("pr.g1b", a_m1_gnt, 1'b1);
        next_cycle();
        idle();
        for (int p = 2; p < 6; p++) begin
            @(negedge clk);
            chk1($sformatf("pr%0d.rv0", p), a_m0_rvalid, p == 3);
            chk1($sformatf("pr%0d.rv1", p), a_m1_rvalid, p == 4);
            if (p == 3) chk16("pr.rd0", a_m0_rdata, 16'h30CF);
            if (p == 4) chk16("pr.rd1", a_m1_rdata, 16'h06F9);
            next_cycle();
        end

`ifdef DPORT_ARBITER_LOCK_EN
        // Master 0 locks with a read, holds off master 1, unlocks with a write
        drive(1'b1, 2'd0, 16'h0001, 16'h0, 1'b0, 2'd0, 16'h0, 16'h0);
        m0_lock = 1'b1;
        @(negedge clk);
        chk1("lk0.g0", a_m0_gnt, 1'b1);
        next_cycle();
        for (int k = 1; k < 3; k++) begin
            drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd0, 16'h0002, 16'h0);
            m0_lock = 1'b0;
            @(negedge clk);
            chk1($sformatf("lk%0d.g1", k), a_m1_gnt, 1'b0);
            next_cycle();
        end
        drive(1'b1, 2'b11, 16'h0040, 16'h1111, 1'b1, 2'd0, 16'h0002, 16'h0);
        m0_lock = 1'b0;
        @(negedge clk);
        chk1("lk3.g0", a_m0_gnt, 1'b1);
        chk1("lk3.g1", a_m1_gnt, 1'b0);
        next_cycle();
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd0, 16'h0002, 16'h0);
        @(negedge clk);
        chk1("lk4.g1", a_m1_gnt, 1'b1);
        next_cycle();
        idle();
        repeat (4) next_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
